// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed seven-segment scan controller
// Double-buffered digit word, dead time between digits, leading-zero blanking.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0] display, display_nxt;
  logic [4*NUM_DIGITS-1:0] pending, pending_nxt;
  logic                    ready_nxt;
  logic                    enter_d0;
  logic                    zero_run;
  logic                    lz_blank;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    fd_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    display_nxt = display;
    pending_nxt = pending;
    ready_nxt   = load_ready;
    enter_d0    = 1'b0;
    zero_run    = 1'b1;
    lz_blank    = 1'b0;
    seg_nxt     = '0;
    an_nxt      = '0;
    fd_nxt      = 1'b0;

    if (!enable) begin
      state_nxt = S_BLANK;
      idx_nxt   = IDX_LAST;
      cnt_nxt   = '0;
    end else if (state == S_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_nxt = S_ON;
        cnt_nxt   = '0;
        enter_d0  = (idx == IDX_LAST);
        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt == ON_LAST) begin
        state_nxt = S_BLANK;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    // Commit and accept are exclusive: commit needs a full buffer, accept an empty one.
    if (!load_ready && (enter_d0 || !enable)) begin
      display_nxt = pending;
      ready_nxt   = 1'b1;
    end else if (load_ready && load_valid) begin
      pending_nxt = load_data;
      ready_nxt   = 1'b0;
    end

    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (display_nxt[4*k +: 4] == 4'd0);
      if (k == int'(idx_nxt)) lz_blank = blank_lz && (k != 0) && zero_run;
    end

    if (state_nxt == S_ON && !lz_blank) begin
      an_nxt[idx_nxt] = 1'b1;
      seg_nxt         = decode(display_nxt[4*idx_nxt +: 4]);
    end
    fd_nxt = enter_d0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BLANK;
      idx        <= IDX_LAST;
      cnt        <= '0;
      display    <= '0;
      pending    <= '0;
      load_ready <= 1'b1;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      display    <= display_nxt;
      pending    <= pending_nxt;
      load_ready <= ready_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - scoreboard bench for sevenseg_scan_ctrl
// Frame-position reference model feeds an expectation queue; a negedge monitor drains it.
module tb_sevenseg_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int B     = 1;
  localparam int SLOT  = R + B;
  localparam int FRAME = N * SLOT;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          blank_lz;
  logic          load_valid;
  logic          load_ready;
  logic [4*N-1:0] load_data;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic          frame_done;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .blank_lz  (blank_lz),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  seg_tab [0:15];
  logic [12:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  // Reference model: enabled-edge count since restart, shown word, pending word.
  int          m_e    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_full = 1'b0;

  task automatic step(input logic r, input logic en, input logic lz,
                      input logic vld, input logic [15:0] d);
    int p, j, o;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_fd;
    rst = r; enable = en; blank_lz = lz; load_valid = vld; load_data = d;
    x_an = '0; x_seg = '0; x_fd = 1'b0;
    if (r) begin
      m_e = 0; m_disp = '0; m_full = 1'b0;
    end else begin
      p = m_e % FRAME;
      if (m_full && (!en || p == 0)) begin
        m_disp = m_pend; m_full = 1'b0;
      end else if (!m_full && vld) begin
        m_pend = d; m_full = 1'b1;
      end
      if (en) begin
        j = p / SLOT;
        o = p % SLOT;
        if (o < R && !(lz && j > 0 && (m_disp >> (4*j)) == 16'd0)) begin
          x_an  = 4'(1 << j);
          x_seg = seg_tab[m_disp[4*j +: 4]];
        end
        x_fd = (p == 0);
        m_e  = m_e + 1;
      end else begin
        m_e = 0;
      end
    end
    exp_q.push_back({~m_full, x_fd, x_an, x_seg});
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input logic r, input logic en, input logic lz,
                     input logic vld, input logic [15:0] d);
    for (int i = 0; i < n; i++) step(r, en, lz, vld, d);
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({load_ready, frame_done, an, seg} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got ready=%b fd=%b an=%b seg=%h exp ready=%b fd=%b an=%b seg=%h",
                 $time, load_ready, frame_done, an, seg, e[12], e[11], e[10:7], e[6:0]);
      end
    end
  end

  initial begin
    logic lz_r;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    run(3, 1, 0, 0, 0, 16'h0);
    run(25, 0, 1, 0, 0, 16'h0);
    run(2, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 1, 16'h1234);
    run(42, 0, 1, 0, 0, 16'h0);
    step(0, 1, 1, 1, 16'h0070);
    run(45, 0, 1, 1, 0, 16'h0);
    run(20, 0, 1, 0, 0, 16'h0);
    step(0, 1, 1, 1, 16'h0000);
    run(45, 0, 1, 1, 0, 16'h0);
    step(0, 1, 0, 1, 16'hA0F9);
    run(45, 0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 1, 16'h1234);
    run(47, 0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 1, 16'h5678);
    run(50, 0, 1, 0, 1, 16'h9999);
    run(12, 0, 1, 0, 0, 16'h0);
    run(3, 0, 0, 0, 0, 16'h0);
    run(30, 0, 1, 0, 0, 16'h0);
    run(7, 0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 1, 16'h4321);
    step(1, 1, 0, 0, 16'h0);
    run(25, 0, 1, 0, 0, 16'h0);

    lz_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) lz_r = ~lz_r;
      step(($urandom_range(199) == 0), ($urandom_range(29) != 0), lz_r,
           ($urandom_range(7) == 0), 16'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for an NUM_DIGITS-digit seven-segment display built around the BCD-to-segment decode function. It holds a tear-free double-buffered digit register loaded through a valid/ready handshake. It drives one shared segment bus plus one-hot digit enables, with dead time between digits, leading-zero blanking, and a dash for non-BCD codes. It sits between the system register interface and the display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 50000, clock cycles each digit is lit (ON phase, >=1)
BLANK_CYCLES, 16, dead-time cycles between digits with all outputs off (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
enable  input  1  scan enable; low forces display dark
blank_lz  input  1  1 = blank leading zeros
load_valid  input  1  new digit word offered
load_ready  output  1  pending buffer empty, word will be accepted
load_data  input  4*NUM_DIGITS  BCD digits, nibble k = digit k, digit 0 = bits [3:0] = least significant
seg  output  7  {g,f,e,d,c,b,a}, active high, registered
an  output  NUM_DIGITS  one-hot digit enable, active high, registered
frame_done  output  1  one-cycle pulse at each frame start / display commit

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset values: seg=0, an=0, frame_done=0, load_ready=1. Display register=0, pending empty.
- Reset FSM state: BLANK, digit index NUM_DIGITS-1, counter 0. Reset mid-operation: same values, pending word discarded.
- FSM states: BLANK and ON.
  - BLANK lasts BLANK_CYCLES enabled cycles, then goes to ON for index+1, wrapping NUM_DIGITS-1 -> 0.
  - ON lasts REFRESH_DIV cycles, then goes to BLANK.
- In ON for digit k: an = one-hot k, seg = decode(display[k]). In BLANK: an=0, seg=0.
- Decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Codes 10..15 = 0x40 (dash).
- Leading-zero blanking: when blank_lz=1, digit k (k>0) is blanked if nibbles k..NUM_DIGITS-1 are all 0. A blanked digit gives an=0 and seg=0 for its ON slot; slot timing is unchanged. Digit 0 is never blanked.
- Timing: first enabled edge after reset starts the BLANK cycle before digit 0, so an[0] rises at enabled edge BLANK_CYCLES. Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Handshake: load_ready = pending empty. A word is accepted when load_valid && load_ready on a clock edge. It is written to pending and load_ready drops the next cycle. load_data is ignored when load_ready=0.
- Commit: on the edge entering ON for digit 0, pending (if full) is copied to the display register and pending empties. That digit-0 slot already shows the new data. frame_done=1 during that first ON cycle, whether or not a commit occurred. A word accepted on the commit edge itself commits at the next frame.
- enable=0, sampled synchronously: next edge FSM returns to reset state, an=0, seg=0, frame_done=0. While disabled a full pending buffer commits to display on every edge. Handshake stays operational. Re-enable restarts as after reset.
- No other combinational path from inputs to seg/an/frame_done. load_ready is a register output.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset: hold rst 3 cycles, then enable=1, no load -> seg=0, an=0 throughout reset; load_ready=1. After release, digit slots show 0x3F with an 0001, 0010, 0100, 1000; each an high 4 cycles, 1 dark cycle between; period 20.
- Load 0x1234 before enable -> an=0001/seg=0x66, 0010/0x4F, 0100/0x5B, 1000/0x06; frame_done pulses every 20 cycles aligned with an[0] rising.
- blank_lz=1, data 0x0070 -> digits 3,2 give an=0, seg=0. Digit1 seg=0x07, digit0 seg=0x3F. With blank_lz=0, digits 3,2 show 0x3F. Data 0x0000 with blank_lz=1: only digit0 lit, 0x3F.
- Data 0xA0F9 -> digit0 0x6F, digit1 0x40, digit2 0x3F (not leading), digit3 0x40.
- Mid-frame load 0x5678 while showing 0x1234 -> remaining digits still show 1,2,3 codes. load_ready=0, and a second offer 0x9999 held valid is not taken. At the next frame_done, digit0 shows 0x7F (8). load_ready=1 the cycle after commit; the held 0x9999 is accepted then and appears the following frame.
- Drop enable during digit2 ON -> an=0, seg=0 next edge. Reassert -> an[0] rises 1 cycle later. Assert rst during ON with a pending word -> outputs 0, load_ready=1, pending lost, display returns to 0.
